counter_8bit: RTL and testbench
===============================

Name: counter_8bit

Overview:
- Synchronous 8-bit up/down binary counter with count enable, direction select and terminal-count carry/borrow output.
- General-purpose leaf block for timers, event counters and address sequencers.
- Targets roughly 1 GHz operation; single register stage, no multicycle paths.

Parameters:
- WIDTH, 8, counter width in bits. Q is WIDTH bits; all arithmetic is modulo 2^WIDTH.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-low reset; sampled on rising Clk edge.
- E  input  1  count enable; 1 = count, 0 = hold.
- M  input  1  direction; 1 = up (+1), 0 = down (-1).
- Q  output  WIDTH  current count, driven directly from the register.
- Cout  output  1  terminal-count carry/borrow, combinational from Q, E and M.

Behaviour:
- Interface: one clock (Clk); reset (Reset) is synchronous and active-low.
- Priority at each rising Clk edge:
  1. Reset=0: Q <= 0. Overrides E and M.
  2. Else E=1 and M=1: Q <= Q + 1, modulo 2^WIDTH.
  3. Else E=1 and M=0: Q <= Q - 1, modulo 2^WIDTH.
  4. Else (E=0): Q holds its value.
- Reset value: Q = 8'h00. Cout follows the formula below, so Cout = 1 only if E=1 and M=0 while Q=00.
- Latency: Q reflects a change one edge after E and M are sampled. No pipeline. E/M changes between edges have no effect until the next edge.
- Wrap-around (default build):
  - Up from FF gives 00.
  - Down from 00 gives FF.
  - No sticky state.
- Cout = E & ((M & (Q == all-ones)) | (~M & (Q == 0))).
  - Asserted during the cycle in which the next enabled edge wraps.
  - Purely combinational; no register.
- Reset asserted mid-count: Q = 00 on that edge; counting resumes on the first edge with Reset=1 and E=1.
- Reset deasserted with E=1: the first increment occurs on the first edge that samples Reset=1.
- Direction change while enabled: takes effect on the next edge. No dead cycle.
- X/Z on E or M while Reset=1 is illegal. Q must never go X after reset.

Optional Feature:
- Macro: COUNTER_8BIT_SAT_EN.
- Defined:
  - Counter saturates: up at all-ones holds all-ones; down at 0 holds 0.
  - Cout behaves as defined above and flags the saturated condition.
- Undefined (default): modulo wrap-around as specified in Behaviour.
- Reset and hold behaviour are identical in both builds.

Decomposition:
- Package counter_8bit_pkg:
  - localparam CNT_W = 8.
  - Direction constants DIR_UP = 1'b1, DIR_DOWN = 1'b0.
  - Constants CNT_MAX (all-ones) and CNT_MIN (0).
- Sub-module counter_8bit_next is natural: pure combinational next-value and Cout logic (inputs Q, E, M; outputs Q_next, Cout), with the SAT_EN variant inside it.
- The top level holds only the register and the reset mux.

Test Plan:
- Reset=0 for 5 cycles, then Reset=1 with E=0 for 3 cycles -> Q = 00 throughout; Cout = 0.
- From 00, E=1, M=1 for 10 rising edges, checked at negedge -> Q = 0A.
- From 0A, E=0 for 5 edges -> Q stays 0A.
- Then E=1, M=0 for 5 edges -> Q = 05.
- Reset, then E=1, M=1 for 256 edges -> Q = 00. Cout = 1 exactly while Q = FF.
- From 00, E=1, M=0 for 1 edge -> Cout = 1 before the edge, Q = FF after.
- Under COUNTER_8BIT_SAT_EN, the same up-count stops at FF. Reset=0 asserted mid-count at Q = 37 -> Q = 00 on that edge.

Source files
------------

// File: rtl/counter_8bit_pkg.sv
// Shared constants for the counter_8bit up/down counter.
package counter_8bit_pkg;

    localparam int unsigned CNT_W = 8;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

endpackage : counter_8bit_pkg

// File: rtl/counter_8bit_next.sv
// Next-count and terminal-count logic for counter_8bit.
// Build option: define COUNTER_8BIT_SAT_EN to saturate at the ends
// instead of wrapping modulo 2^WIDTH.
module counter_8bit_next
    import counter_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic [WIDTH-1:0] i_q,
    input  logic             i_e,
    input  logic             i_m,
    output logic [WIDTH-1:0] o_q_next_c,
    output logic             o_cout_c
);

    logic w_at_max;
    logic w_at_min;
    logic w_up;
    logic w_down;

    assign w_at_max = (i_q == {WIDTH{1'b1}});
    assign w_at_min = (i_q == {WIDTH{1'b0}});
    assign w_up     = i_e & (i_m == DIR_UP);
    assign w_down   = i_e & (i_m == DIR_DOWN);

    // Terminal count: the next enabled edge would cross an end of the range.
    assign o_cout_c = (w_up & w_at_max) | (w_down & w_at_min);

    // Next count value; hold when disabled.
    always_comb begin
        o_q_next_c = i_q;
`ifdef COUNTER_8BIT_SAT_EN
        if (w_up && !w_at_max) begin
            o_q_next_c = i_q + WIDTH'(1);
        end else if (w_down && !w_at_min) begin
            o_q_next_c = i_q - WIDTH'(1);
        end
`else
        if (w_up) begin
            o_q_next_c = i_q + WIDTH'(1);
        end else if (w_down) begin
            o_q_next_c = i_q - WIDTH'(1);
        end
`endif
    end

endmodule : counter_8bit_next

// File: rtl/counter_8bit.sv
// counter_8bit: synchronous up/down counter with enable and carry/borrow.
// Build option: COUNTER_8BIT_SAT_EN selects saturating instead of wrapping.
module counter_8bit
    import counter_8bit_pkg::*;
#(
    parameter int unsigned WIDTH = CNT_W
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             E,
    input  logic             M,
    output logic [WIDTH-1:0] Q,
    output logic             Cout
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_d;

    counter_8bit_next #(
        .WIDTH      (WIDTH)
    ) u_next (
        .i_q        (r_q),
        .i_e        (E),
        .i_m        (M),
        .o_q_next_c (w_q_next),
        .o_cout_c   (Cout)
    );

    // Synchronous reset overrides counting.
    assign w_q_d = Reset ? w_q_next : {WIDTH{1'b0}};

    // Count register.
    always_ff @(posedge Clk) begin
        r_q <= w_q_d;
    end

    assign Q = r_q;

endmodule : counter_8bit

// File: tb/tb_counter_8bit.sv
// Self-checking bench for counter_8bit (default and COUNTER_8BIT_SAT_EN builds).
module tb_counter_8bit;
    import counter_8bit_pkg::*;

    logic       Clk;
    logic       Reset;
    logic       E;
    logic       M;
    logic [7:0] Q;
    logic       Cout;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [7:0] mq = 8'h00;
    logic [7:0] sb_q[$];

    counter_8bit dut (
        .Clk   (Clk),
        .Reset (Reset),
        .E     (E),
        .M     (M),
        .Q     (Q),
        .Cout  (Cout)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] model_next(input logic [7:0] q,
                                              input logic rst, input logic e,
                                              input logic m);
        logic [7:0] n;
        n = q;
        if (!rst) begin
            n = 8'h00;
        end else if (e) begin
`ifdef COUNTER_8BIT_SAT_EN
            if (m) n = (q == 8'hFF) ? q : q + 8'd1;
            else   n = (q == 8'h00) ? q : q - 8'd1;
`else
            if (m) n = q + 8'd1;
            else   n = q - 8'd1;
`endif
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock step: drive inputs, check Cout before the edge, check Q after.
    task automatic step(input logic rst, input logic e, input logic m,
                        input string tag);
        logic [7:0] exp_q;
        logic       exp_c;
        Reset = rst;
        E     = e;
        M     = m;
        #1;
        exp_c = e & (m ? (mq == 8'hFF) : (mq == 8'h00));
        check({tag, "_cout"}, {7'd0, Cout}, {7'd0, exp_c});
        mq = model_next(mq, rst, e, m);
        sb_q.push_back(mq);
        @(posedge Clk);
        #1;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'h01, 8'h00);
        end else begin
            exp_q = sb_q.pop_front();
            check({tag, "_q"}, Q, exp_q);
        end
    endtask

    initial begin
        Reset = 1'b0;
        E     = 1'b0;
        M     = 1'b0;
        @(posedge Clk);
        #1;
        mq = 8'h00;

        // Reset held, enable asserted: reset must win.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1, DIR_UP, "reset_hold");
        check("reset_val", Q, CNT_MIN);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DIR_UP, "idle");
        check("idle_val", Q, 8'h00);

        // Count up 10.
        for (int i = 0; i < 10; i++) step(1'b1, 1'b1, DIR_UP, "up10");
        check("up10_val", Q, 8'h0A);

        // Hold.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, DIR_UP, "hold");
        check("hold_val", Q, 8'h0A);

        // Count down 5.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, DIR_DOWN, "down5");
        check("down5_val", Q, 8'h05);

        // Full up sweep of 256 edges.
        step(1'b0, 1'b0, DIR_UP, "sweep_rst");
        for (int i = 0; i < 256; i++) step(1'b1, 1'b1, DIR_UP, "sweep");
`ifdef COUNTER_8BIT_SAT_EN
        check("sweep_end", Q, CNT_MAX);
`else
        check("sweep_end", Q, CNT_MIN);
`endif

        // Borrow from zero.
        step(1'b0, 1'b0, DIR_UP, "borrow_rst");
        step(1'b1, 1'b1, DIR_DOWN, "borrow");
`ifdef COUNTER_8BIT_SAT_EN
        check("borrow_val", Q, CNT_MIN);
`else
        check("borrow_val", Q, CNT_MAX);
`endif

        // Reset mid-count at 0x37, then resume.
        step(1'b0, 1'b0, DIR_UP, "mid_rst0");
        for (int i = 0; i < 8'h37; i++) step(1'b1, 1'b1, DIR_UP, "to37");
        check("at37", Q, 8'h37);
        step(1'b0, 1'b1, DIR_UP, "mid_rst");
        check("mid_rst_val", Q, 8'h00);
        step(1'b1, 1'b1, DIR_UP, "resume");
        check("resume_val", Q, 8'h01);

        // Direction change while enabled, no dead cycle.
        step(1'b1, 1'b1, DIR_UP, "dir_up");
        step(1'b1, 1'b1, DIR_DOWN, "dir_dn");
        check("dir_val", Q, 8'h01);

        // Randomised enable/direction with occasional reset.
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 31) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), "rand");
        end

        check("sb_drained", 8'(sb_q.size()), 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_counter_8bit
